// File: rtl/canon_seq_pkg.sv
// Shared definitions for the canon voice sequencer.
//   - score entry field positions: {dur_code[2:0], note[4:0]}
//   - rest note code
//   - note -> divider table for the 36 MHz clock (index 0 is the rest)
//   - walker FSM state type
package canon_seq_pkg;

  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 5;
  localparam int NOTE_MSB = 4;
  localparam int NOTE_LSB = 0;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam int         NOTE_MAX  = 17;

  localparam int unsigned DIV_TABLE [0:17] = '{
    0,
    568, 506, 477, 425, 379, 357, 318, 283, 252,
    238, 212, 189, 178, 158, 141, 125, 118
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FETCH = 2'd2,
    ST_LOAD  = 2'd3
  } walk_state_t;

endpackage

// File: rtl/canon_voice_sequencer_if.sv
// Score ROM bus of the canon voice sequencer.
//   rom_rd   : read strobe from the sequencer
//   rom_addr : score address
//   rom_data : {dur_code[2:0], note[4:0]}, valid the cycle after rom_rd
// master = sequencer side, slave = ROM side.
interface canon_voice_sequencer_if #(
  parameter int IDX_W = 9
);
  logic             rom_rd;
  logic [IDX_W-1:0] rom_addr;
  logic [7:0]       rom_data;

  modport master (output rom_rd, output rom_addr, input rom_data);
  modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/canon_voice_sequencer_note_to_divider.sv
// Combinational note -> divider lookup.
//   note    : 5-bit note code, 0 = rest
//   divider : divider value; 0 for rest and for codes above the table
module note_to_divider
  import canon_seq_pkg::*;
#(
  parameter int DIV_W = 11
) (
  input  logic [4:0]       note,
  output logic [DIV_W-1:0] divider
);

  always_comb begin
    divider = '0;
    if (note != NOTE_REST && int'(note) <= NOTE_MAX) begin
      divider = DIV_W'(DIV_TABLE[note]);
    end
  end

endmodule

// File: rtl/canon_voice_sequencer.sv
// N-voice canon sequencer. All voices walk one shared score; voice i enters
// i*CANON_OFFSET beats after reset. A walker FSM services the voices once per
// beat, reading the external ROM through the rom bus. Voices are
// time-multiplexed onto one registered divider output, one voice per clock.
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   enable        : run; low freezes the beat counter
//   tempo_div     : beat period minus 1 in clocks (taken at each beat wrap)
//   loop_start/end: score loop window
//   fast_start    : (SEQ_FAST_START_EN only) start offset, 16 entries/step
//   rom           : score ROM bus (master side)
//   slot, divider : TDM voice index and its divider, aligned
//   beat          : one-cycle pulse per beat
//   voice_active  : per-voice entered flag
//   overrun       : sticky, a beat was dropped
//
// Build option: define SEQ_FAST_START_EN to add the fast_start input.
//
// Walker states:
//   state    | meaning
//   ST_IDLE  | waiting for a pending beat
//   ST_CHECK | voice vsel: count down its note, or fetch if due
//   ST_FETCH | rom read of ptr[vsel]
//   ST_LOAD  | capture note/duration, advance ptr[vsel]
module canon_voice_sequencer
  import canon_seq_pkg::*;
#(
  parameter int N_VOICES     = 4,
  parameter int IDX_W        = 9,
  parameter int DIV_W        = 11,
  parameter int BEAT_W       = 22,
  parameter int CANON_OFFSET = 8,
  localparam int SLOT_W      = $clog2(N_VOICES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [BEAT_W-1:0]   tempo_div,
  input  logic [IDX_W-1:0]    loop_start,
  input  logic [IDX_W-1:0]    loop_end,
`ifdef SEQ_FAST_START_EN
  input  logic [1:0]          fast_start,
`endif
  canon_voice_sequencer_if.master rom,
  output logic [SLOT_W-1:0]   slot,
  output logic [DIV_W-1:0]    divider,
  output logic                beat,
  output logic [N_VOICES-1:0] voice_active,
  output logic                overrun
);

  localparam int ENT_W = $clog2(N_VOICES * CANON_OFFSET + 2);

  logic [1:0] fs;
`ifdef SEQ_FAST_START_EN
  assign fs = fast_start;
`else
  assign fs = 2'b00;
`endif

  function automatic logic [ENT_W-1:0] entry_init(input int idx, input logic [1:0] f);
    int e;
    e = idx * CANON_OFFSET - int'(f);
    if (e < 0) e = 0;
    return ENT_W'(e);
  endfunction

  logic [IDX_W-1:0] ptr_init;
  assign ptr_init = loop_start + IDX_W'({fs, 4'b0000});

  // ---------------- beat generator ----------------
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] tempo_q;
  logic              beat_ev;

  assign beat_ev = enable && (beat_cnt == tempo_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      tempo_q  <= tempo_div;
      beat     <= 1'b0;
    end else begin
      beat <= beat_ev;
      if (beat_ev) begin
        beat_cnt <= '0;
        tempo_q  <= tempo_div;
      end else if (enable) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // ---------------- voice entry counters ----------------
  logic [ENT_W-1:0]    entry      [N_VOICES];
  logic [ENT_W-1:0]    entry_next [N_VOICES];
  logic [N_VOICES-1:0] act;

  always_comb begin
    act = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      entry_next[i] = entry[i];
      if (beat_ev && entry[i] != '0) entry_next[i] = entry[i] - ENT_W'(1);
      act[i] = (entry[i] == '0);
    end
  end

  // voice_active follows the post-beat counter so it rises with the beat pulse
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_VOICES; i++) begin
      if (!rst_n) begin
        entry[i]        <= entry_init(i, fs);
        voice_active[i] <= 1'b0;
      end else begin
        entry[i]        <= entry_next[i];
        voice_active[i] <= (entry_next[i] == '0);
      end
    end
  end

  // ---------------- walker FSM ----------------
  walk_state_t       state, state_next;
  logic [SLOT_W-1:0] vsel, vsel_next;
  logic              last_voice;
  logic              pending;
  logic              start;

  logic [IDX_W-1:0]  ptr  [N_VOICES];
  logic [2:0]        rem  [N_VOICES];
  logic [4:0]        note [N_VOICES];

  logic              rom_rd_c;
  logic [IDX_W-1:0]  rom_addr_c;
  logic              chk_dec;
  logic              load_en;

  assign last_voice = (vsel == SLOT_W'(N_VOICES - 1));
  assign start      = (state == ST_IDLE) && pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vsel  <= '0;
    end else begin
      state <= state_next;
      vsel  <= vsel_next;
    end
  end

  always_comb begin
    state_next = state;
    vsel_next  = vsel;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_next = ST_CHECK;
          vsel_next  = '0;
        end
      end
      ST_CHECK: begin
        if (!act[vsel] || rem[vsel] != 3'd0) begin
          if (last_voice) state_next = ST_IDLE;
          else            vsel_next  = vsel + SLOT_W'(1);
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD: begin
        if (last_voice) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_CHECK;
          vsel_next  = vsel + SLOT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_rd_c   = 1'b0;
    rom_addr_c = '0;
    chk_dec    = 1'b0;
    load_en    = 1'b0;
    case (state)
      ST_CHECK: chk_dec = (rem[vsel] != 3'd0);
      ST_FETCH: begin
        rom_rd_c   = 1'b1;
        rom_addr_c = ptr[vsel];
      end
      ST_LOAD:  load_en = 1'b1;
      default: ;
    endcase
  end

  // Gated by rst_n so a reset mid-fetch kills the strobe immediately.
  assign rom.rom_rd   = rom_rd_c && rst_n;
  assign rom.rom_addr = rst_n ? rom_addr_c : '0;

  // Reset leaves pending set: the start-up walk plays beat 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b1;
      overrun <= 1'b0;
    end else begin
      pending <= beat_ev || (pending && !start);
      if (beat_ev && pending && !start) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_VOICES; i++) begin
      if (!rst_n) begin
        ptr[i]  <= ptr_init;
        rem[i]  <= 3'd0;
        note[i] <= NOTE_REST;
      end else if (load_en && vsel == SLOT_W'(i)) begin
        note[i] <= rom.rom_data[NOTE_MSB:NOTE_LSB];
        rem[i]  <= rom.rom_data[DUR_MSB:DUR_LSB];
        ptr[i]  <= (ptr[i] == loop_end) ? loop_start : ptr[i] + IDX_W'(1);
      end else if (chk_dec && vsel == SLOT_W'(i)) begin
        rem[i] <= rem[i] - 3'd1;
      end
    end
  end

  // ---------------- TDM output ----------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [4:0]        tdm_note;
  logic [DIV_W-1:0]  tdm_div;

  assign tdm_note = note[slot_cnt];

  note_to_divider #(.DIV_W(DIV_W)) u_ntd (
    .note    (tdm_note),
    .divider (tdm_div)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      slot     <= '0;
      divider  <= '0;
    end else begin
      slot     <= slot_cnt;
      divider  <= act[slot_cnt] ? tdm_div : '0;
      slot_cnt <= (slot_cnt == SLOT_W'(N_VOICES - 1)) ? '0 : slot_cnt + SLOT_W'(1);
    end
  end

endmodule

// File: tb/tb_canon_voice_sequencer.sv
module tb_canon_voice_sequencer;

  localparam int N      = 4;
  localparam int IDX_W  = 9;
  localparam int DIV_W  = 11;
  localparam int BEAT_W = 22;
  localparam int OFF    = 8;

  localparam int unsigned TBL [18] = '{0, 568, 506, 477, 425, 379, 357, 318, 283,
                                       252, 238, 212, 189, 178, 158, 141, 125, 118};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [BEAT_W-1:0] tempo_div;
  logic [IDX_W-1:0]  loop_start, loop_end;
`ifdef SEQ_FAST_START_EN
  logic [1:0]        fast_start = 2'b00;
`endif
  logic [1:0]        slot;
  logic [DIV_W-1:0]  divider;
  logic              beat;
  logic [N-1:0]      voice_active;
  logic              overrun;

  canon_voice_sequencer_if #(.IDX_W(IDX_W)) rom_if ();

  canon_voice_sequencer #(
    .N_VOICES(N), .IDX_W(IDX_W), .DIV_W(DIV_W), .BEAT_W(BEAT_W), .CANON_OFFSET(OFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .tempo_div    (tempo_div),
    .loop_start   (loop_start),
    .loop_end     (loop_end),
`ifdef SEQ_FAST_START_EN
    .fast_start   (fast_start),
`endif
    .rom          (rom_if),
    .slot         (slot),
    .divider      (divider),
    .beat         (beat),
    .voice_active (voice_active),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // single-port score ROM, one-cycle latency
  logic [7:0] score [512];
  always @(posedge clk) if (rom_if.rom_rd) rom_if.rom_data <= score[rom_if.rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DIV_W-1:0] ref_div(input logic [4:0] n);
    if (n >= 5'd1 && n <= 5'd17) return DIV_W'(TBL[n]);
    return '0;
  endfunction

  // ---------------- reference model: beat-level schedule ----------------
  typedef struct packed {
    logic [N-1:0][DIV_W-1:0] d;
    logic [N-1:0]            act;
  } snap_t;

  logic [IDX_W-1:0] exp_addr_q [$];
  snap_t            exp_snap_q [$];

  // Walk w is the service pass triggered by beat w (w=0 at start-up).
  // A voice enters at walk v*OFF and refetches dur+1 walks after each fetch.
  task automatic build_model(input int walks, input logic [IDX_W-1:0] ls, input logic [IDX_W-1:0] le);
    int               nxt [N];
    logic [IDX_W-1:0] p   [N];
    logic [4:0]       cur [N];
    logic [7:0]       e;
    snap_t            s;
    exp_addr_q.delete();
    exp_snap_q.delete();
    for (int v = 0; v < N; v++) begin
      nxt[v] = v * OFF;
      p[v]   = ls;
      cur[v] = 5'd0;
    end
    for (int w = 0; w < walks; w++) begin
      for (int v = 0; v < N; v++) begin
        if (w == nxt[v]) begin
          exp_addr_q.push_back(p[v]);
          e      = score[p[v]];
          cur[v] = e[4:0];
          nxt[v] = w + int'(e[7:5]) + 1;
          p[v]   = (p[v] == le) ? ls : p[v] + IDX_W'(1);
        end
      end
      for (int v = 0; v < N; v++) begin
        s.d[v]   = (w >= v * OFF) ? ref_div(cur[v]) : '0;
        s.act[v] = ((w + 1) >= v * OFF);
      end
      exp_snap_q.push_back(s);
    end
  endtask

  // ---------------- monitor ----------------
  bit               mon_en = 1'b0;
  int               beat_seen = 0;
  logic [DIV_W-1:0] last_div [N];

  always @(negedge clk) begin
    if (mon_en) begin
      logic [IDX_W-1:0] ea;
      snap_t            s;
      last_div[slot] = divider;
      if (rom_if.rom_rd) begin
        if (exp_addr_q.size() == 0) begin
          chk("rom_read_unexpected", 64'(rom_if.rom_addr), 64'hFFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("rom_addr", 64'(rom_if.rom_addr), 64'(ea));
        end
      end
      if (beat) begin
        beat_seen++;
        if (exp_snap_q.size() == 0) begin
          chk("beat_unexpected", 64'(beat_seen), 64'hFFFF);
        end else begin
          s = exp_snap_q.pop_front();
          for (int v = 0; v < N; v++) chk($sformatf("divider_v%0d_beat%0d", v, beat_seen), 64'(last_div[v]), 64'(s.d[v]));
          chk($sformatf("voice_active_beat%0d", beat_seen), 64'(voice_active), 64'(s.act));
        end
      end
    end
  end

  task automatic wait_beats(input int n);
    int cyc;
    cyc = 0;
    while (beat_seen < n && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk("beat_progress", 64'(beat_seen >= n), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_slot"},         64'(slot),            64'd0);
    chk({tag, "_divider"},      64'(divider),         64'd0);
    chk({tag, "_beat"},         64'(beat),            64'd0);
    chk({tag, "_voice_active"}, 64'(voice_active),    64'd0);
    chk({tag, "_overrun"},      64'(overrun),         64'd0);
    chk({tag, "_rom_rd"},       64'(rom_if.rom_rd),   64'd0);
    chk({tag, "_rom_addr"},     64'(rom_if.rom_addr), 64'd0);
  endtask

  initial begin
    int nb, nr, k;

    // ---- A: random score, loop 0..15, tempo 99, enable pause mid-song ----
    tempo_div  = BEAT_W'(99);
    loop_start = IDX_W'(0);
    loop_end   = IDX_W'(15);
    enable     = 1'b1;
    for (int i = 0; i < 512; i++) score[i] = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
    score[0] = {3'd1, 5'd12};
    score[1] = {3'd0, 5'd0};
    score[2] = {3'd1, 5'd25};
    do_reset();
    chk_reset_outputs("reset");
    build_model(40, loop_start, loop_end);
    beat_seen = 0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_beats(12);
    @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    nb = 0;
    nr = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (beat) nb++;
      if (rom_if.rom_rd) nr++;
    end
    chk("enable_low_beats", 64'(nb), 64'd0);
    chk("enable_low_reads", 64'(nr), 64'd0);
    enable = 1'b1;
    wait_beats(40);
    mon_en = 1'b0;
    chk("A_addr_queue_left", 64'(exp_addr_q.size()), 64'd0);
    chk("A_snap_queue_left", 64'(exp_snap_q.size()), 64'd0);
    chk("A_overrun", 64'(overrun), 64'd0);

    // ---- B: loop 5..7, all durations 0 ----
    loop_start = IDX_W'(5);
    loop_end   = IDX_W'(7);
    for (int i = 0; i < 512; i++) score[i] = {3'd0, 5'($urandom_range(0, 31))};
    do_reset();
    build_model(30, loop_start, loop_end);
    beat_seen = 0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_beats(30);
    mon_en = 1'b0;
    chk("B_addr_queue_left", 64'(exp_addr_q.size()), 64'd0);
    chk("B_snap_queue_left", 64'(exp_snap_q.size()), 64'd0);
    chk("B_overrun", 64'(overrun), 64'd0);

    // ---- C: tempo 3 with every voice fetching each walk -> overrun ----
    tempo_div = BEAT_W'(3);
    do_reset();
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("C_overrun", 64'(overrun), 64'd1);

    // ---- E: reset during a fetch, then slot sequence ----
    k = 0;
    while (!rom_if.rom_rd && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("E_fetch_seen", 64'(rom_if.rom_rd), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("E_rom_rd_drop", 64'(rom_if.rom_rd), 64'd0);
    @(posedge clk);
    #1;
    chk_reset_outputs("E_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("E_slot_%0d", i), 64'(slot), 64'(i % N));
      if (i == 0) chk("E_voice0_active", 64'(voice_active), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
